// File: rtl/rr_mux_arbiter.sv
// Round-robin arbitrated N_CH:1 mux with a registered, handshaked output word.
// The select is produced internally: the scan starts at a rotating pointer so
// every continuously valid producer is served within N_CH load cycles.
module rr_mux_arbiter #(
  parameter int N_CH   = 4,
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b0,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] words [N_CH];
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  gnt;
  logic [CH_W-1:0]  ptr_nxt;
  logic [CH_W-1:0]  scan_idx;
  int               scan_pos;
  logic             any;
  logic             can_load;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [CH_W-1:0]  ch_p1;

  // Optional bitwise NOT of the selected word before it is registered.
  function automatic logic [WIDTH-1:0] shape_word(input logic [WIDTH-1:0] w);
    return INVERT ? ~w : w;
  endfunction

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign words[k]    = in_data[k*WIDTH +: WIDTH];
    assign in_ready[k] = can_load && any && (gnt == CH_W'(k));
  end

  assign can_load = !vld_p1 || out_ready;
  assign ptr_nxt  = (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + CH_W'(1);

  // Grant: first valid channel scanning ptr, ptr+1, ... modulo N_CH.
  always_comb begin
    gnt      = '0;
    any      = 1'b0;
    scan_pos = 0;
    scan_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan_pos = (int'(ptr) + i) % N_CH;
      scan_idx = scan_pos[CH_W-1:0];
      if (!any && in_valid[scan_idx]) begin
        any = 1'b1;
        gnt = scan_idx;
      end
    end
  end

  // ---- stage p1: output register and pointer; frozen while stalled ----
  // Load on a grant, drop valid when idle, hold everything under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else if (can_load) begin
      if (any) begin
        vld_p1  <= 1'b1;
        data_p1 <= shape_word(words[gnt]);
        ch_p1   <= gnt;
        ptr     <= ptr_nxt;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench: the driver predicts each accepted word from a queue-level
// model and pushes it; a monitor pops on every output transfer and compares.
// A second instance with INVERT=1 sees identical stimulus.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  typedef struct {
    int           ch;
    logic [W-1:0] data;
  } word_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;
  logic [N-1:0]   in_ready,  in_ready_i;
  logic           out_valid, out_valid_i;
  logic [W-1:0]   out_data,  out_data_i;
  logic [CW-1:0]  out_ch,    out_ch_i;

  word_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    m_vld = 0;
  int    m_ptr = 0;

  rr_mux_arbiter #(.N_CH(N), .WIDTH(W), .INVERT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready));

  rr_mux_arbiter #(.N_CH(N), .WIDTH(W), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_i), .out_valid(out_valid_i), .out_data(out_data_i),
    .out_ch(out_ch_i), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must deliver the oldest predicted word.
  always @(negedge clk) begin
    word_t        e;
    logic [W-1:0] inv;
    #2;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got unexpected word ch=%0d data=%0h", out_ch, out_data);
      end else begin
        e   = sb.pop_front();
        inv = ~e.data;
        chk("out_data", out_data, e.data);
        chk("out_ch", out_ch, e.ch);
        chk("inv_data", out_data_i, inv);
        chk("inv_ch", out_ch_i, e.ch);
      end
    end
  end

  // One cycle of stimulus plus the reference prediction for the next edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
    logic         can;
    logic         any;
    int           g;
    logic [N-1:0] exp_rdy;
    word_t        w;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    can = (m_vld == 0) || r;
    any = 1'b0;
    g   = 0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (!any && v[c]) begin
        any = 1'b1;
        g   = c;
      end
    end
    exp_rdy = '0;
    if (can && any) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    chk("in_ready_inv", in_ready_i, exp_rdy);
    chk("out_valid", out_valid, m_vld);
    if (can) begin
      if (any) begin
        w.ch   = g;
        w.data = d[g*W +: W];
        sb.push_back(w);
        m_vld  = 1;
        m_ptr  = (g + 1) % N;
      end else begin
        m_vld  = 0;
      end
    end
  endtask

  localparam logic [N*W-1:0] RR_DATA = {8'h13, 8'h12, 8'h11, 8'h10};

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_inv_data", out_data_i, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single channel after reset
    cycle(4'b0100, {8'h00, 8'h5A, 16'h0000}, 1'b1);
    @(posedge clk); #1;
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 8'h5A);
    chk("first_ch", out_ch, 2);
    chk("first_inv", out_data_i, 8'hA5);

    // All valid round-robin
    repeat (8) cycle(4'b1111, RR_DATA, 1'b1);

    // Skip and wrap: grant ch2 leaves ptr=3, then only ch0/ch1 valid
    cycle(4'b0100, RR_DATA, 1'b1);
    repeat (3) cycle(4'b0011, RR_DATA, 1'b1);

    // Backpressure then drain+load on the same edge
    cycle(4'b1111, RR_DATA, 1'b1);
    repeat (3) cycle(4'b1111, RR_DATA, 1'b0);
    repeat (2) cycle(4'b1111, RR_DATA, 1'b1);

    // Idle then resume from saved pointer
    repeat (2) cycle(4'b0000, RR_DATA, 1'b1);
    repeat (3) cycle(4'b1111, RR_DATA, 1'b1);

    // Inversion corner values
    cycle(4'b0010, {16'h0000, 8'hA5, 8'h00}, 1'b1);
    @(posedge clk); #1;
    chk("inv_a5", out_data_i, 8'h5A);
    cycle(4'b0010, '0, 1'b1);
    @(posedge clk); #1;
    chk("inv_00", out_data_i, 8'hFF);

    // Asynchronous reset mid-cycle with a held word
    cycle(4'b0001, {24'h0, 8'h77}, 1'b0);
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_ch", out_ch, 0);
    chk("arst_inv_valid", out_valid_i, 0);
    sb.delete();
    m_vld = 0;
    m_ptr = 0;
    #2;
    rst = 1'b0;
    cycle(4'b0100, {8'h00, 8'h5A, 16'h0000}, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_data", out_data, 8'h5A);
    chk("post_rst_ch", out_ch, 2);

    // Randomised traffic
    repeat (300) begin
      logic [N-1:0] v;
      v = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, 15));
      cycle(v, N*W'($urandom()), $urandom_range(0, 9) < 7);
    end

    repeat (2) cycle(4'b0000, '0, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised successor to the 2:1 combinational mux: an N_CH-input, WIDTH-bit mux whose select is generated internally by a round-robin arbiter.
- Output is registered, with valid/ready handshakes on both sides.
- Optional bitwise inversion of the selected word, a generalised mux-built NOT.
- Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 8, data width per channel.
- INVERT, 0, when 1 the registered output word is the bitwise NOT of the selected input word.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH*WIDTH  flattened; channel k occupies [k*WIDTH +: WIDTH].
- in_ready  output  N_CH  per-channel accept strobe, combinational.
- out_valid  output  1  registered output word valid.
- out_data  output  WIDTH  registered output word.
- out_ch  output  CH_W  channel index of the held word. CH_W = $clog2(N_CH).
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, asynchronous, active-high:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - A word held when rst asserts is dropped and not replayed.
- Transfers:
  - Input transfer on channel k occurs when in_valid[k] && in_ready[k] at a clock edge.
  - Output transfer occurs when out_valid && out_ready.
- can_load = !out_valid || out_ready. Back-to-back words and a simultaneous drain+load are allowed, giving 1 word/cycle throughput.
- Grant selection (combinational):
  - Scan channels ptr, ptr+1, ..., ptr+N_CH-1, all mod N_CH.
  - gnt = the first channel with in_valid set.
  - any = OR of in_valid.
- in_ready[k] = can_load && any && (k==gnt). At most one in_ready bit is high; all are 0 when no channel is valid or the output is stalled.
- On an edge with can_load && any:
  - out_valid<=1.
  - out_data<=in_data[gnt] (inverted if INVERT=1).
  - out_ch<=gnt.
  - ptr<=(gnt+1) mod N_CH.
- On an edge with can_load && !any:
  - out_valid<=0.
  - out_data and out_ch hold their previous values.
  - ptr unchanged.
- On an edge with out_valid && !out_ready:
  - out_valid, out_data, out_ch and ptr are all held stable.
  - No input is accepted.
- Latency: an accepted input appears on out_* on the edge where it is accepted, i.e. 1 cycle from accept to visible.
- No lock between words. Arbitration is re-evaluated every cycle; a channel that withdraws in_valid before being granted loses nothing.
- Fairness: a continuously valid channel is granted within N_CH consecutive load cycles.
- ptr wrap-around: a grant to N_CH-1 sets ptr=0.
- Pointer advances only on an actual grant, never on idle or stall cycles.

Test Plan:
- Reset (N_CH=4, WIDTH=8): assert rst mid-cycle with out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately, without waiting for clk. After release, in_valid=4'b0100 with data 0x5A -> next edge gives out_valid=1, out_data=0x5A, out_ch=2.
- Round-robin, all valid: in_valid=4'b1111, data k=0x10+k, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_data 0x10..0x13 repeating; exactly one in_ready bit high each cycle.
- Skip and wrap: ptr=3 (after a grant on ch2), in_valid=4'b0011 -> grant ch0 (wrap past ch3), then ch1, then ch0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0 throughout; out_* and ptr held. On out_ready=1, the drain and a new load occur on the same edge with no bubble.
- Idle: in_valid=0 with out_ready=1 -> out_valid drops to 0 next edge; ptr is unchanged; the next grant resumes from the saved ptr.
- INVERT=1: single channel valid with data 0xA5 -> out_data=0x5A; with data 0x00 -> out_data=0xFF.
